// File: rtl/stim_counter.sv
// -----------------------------------------------------------------------------
// stim_counter
//
// Sweeps a WIDTH-bit stimulus space for exhaustive checking of combinational
// blocks. It counts in binary-up, binary-down or Gray-up order. It supports a
// synchronous load, pulses `wrap` once per full sweep, and raises a sticky
// `done` flag after SWEEPS full sweeps.
//
// Parameters
//   WIDTH    : counter / output width, 1..16
//   SWEEPS   : number of wraps before `done` asserts, 1..255
//
// Ports
//   clk      in   1      single clock, rising-edge active
//   rst      in   1      synchronous active-high reset
//   en       in   1      advance enable
//   load     in   1      synchronous load strobe (beats en)
//   load_val in   WIDTH  value loaded into the binary state
//   mode     in   2      00 bin up, 01 bin down, 10 Gray up, 11 hold
//   count    out  WIDTH  registered stimulus value
//   wrap     out  1      one-cycle pulse while count shows the wrapped value
//   done     out  1      sticky, set on the edge completing the last sweep
// -----------------------------------------------------------------------------
module stim_counter #(
    parameter int WIDTH  = 2,
    parameter int SWEEPS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             done
);

    localparam int NSW_W = $clog2(SWEEPS + 1);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_GRAY = 2'b10,
        MODE_HOLD = 2'b11
    } mode_t;

    mode_t            w_mode;
    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] w_bin_next;
    logic [NSW_W-1:0] r_nsweep;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap;
    logic             r_done;
    logic             w_advance;
    logic             w_at_boundary;
    logic             w_wrap_evt;
    logic             w_last_sweep;

    assign w_mode = mode_t'(mode);

    // The encoding follows the mode that is sampled on the same edge as the
    // binary value. This makes count track bin and mode together.
    function automatic logic [WIDTH-1:0] encode(input logic [WIDTH-1:0] b,
                                                input mode_t m);
        return (m == MODE_GRAY) ? (b ^ (b >> 1)) : b;
    endfunction

    assign w_advance = en && !r_done && (w_mode != MODE_HOLD);

    // Counting down wraps when leaving 0. Counting up (binary or Gray) wraps
    // when leaving all-ones.
    assign w_at_boundary = (w_mode == MODE_DOWN) ? (r_bin == '0) : (r_bin == '1);
    assign w_wrap_evt    = w_advance && w_at_boundary;
    assign w_last_sweep  = (r_nsweep == NSW_W'(SWEEPS - 1));

    // NOTE: combinational blocks assign a default first, so no path leaves
    // the output unassigned and no latch is inferred.
    always_comb begin
        w_bin_next = r_bin;
        if (w_advance) begin
            if (w_mode == MODE_DOWN) begin
                w_bin_next = r_bin - WIDTH'(1);
            end else begin
                w_bin_next = r_bin + WIDTH'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register then samples pre-edge values, whatever order the statements
    // appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin    <= '0;
            r_nsweep <= '0;
            r_count  <= '0;
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
        end else if (load) begin
            r_bin    <= load_val;
            r_nsweep <= '0;
            r_count  <= encode(load_val, w_mode);
            r_wrap   <= 1'b0;
            r_done   <= 1'b0;
        end else if (r_done) begin
            // Frozen until a reset or load; only the wrap pulse is cleared.
            r_wrap <= 1'b0;
        end else begin
            r_bin   <= w_bin_next;
            r_count <= encode(w_bin_next, w_mode);
            r_wrap  <= w_wrap_evt;
            if (w_wrap_evt) begin
                r_nsweep <= r_nsweep + NSW_W'(1);
                if (w_last_sweep) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign count = r_count;
    assign wrap  = r_wrap;
    assign done  = r_done;

endmodule

// File: tb/tb_stim_counter.sv
// -----------------------------------------------------------------------------
// tb_stim_counter
//
// Two instances share one clock: dut_a (WIDTH=2, SWEEPS=2) and
// dut_b (WIDTH=3, SWEEPS=1). Each cycle the stimulus process drives both
// instances. It then steps a behavioural model and, after the clock edge,
// pushes the predicted outputs into a queue. A separate monitor pops one
// entry per cycle, a few time units after the edge, and compares it with the
// outputs of both instances.
// -----------------------------------------------------------------------------
module tb_stim_counter;

    typedef struct {
        bit rst;
        bit load;
        int lv;
        int mode;
        bit en;
    } in_t;

    typedef struct {
        int  bin;
        int  sweeps;
        int  cnt;
        bit  wrap;
        bit  done;
    } mstate_t;

    typedef struct {
        int ca;
        bit wa;
        bit da;
        int cb;
        bit wb;
        bit db;
    } exp_t;

    logic       clk = 1'b0;
    logic       a_rst, a_en, a_load, a_wrap, a_done;
    logic [1:0] a_lv, a_mode, a_count;
    logic       b_rst, b_en, b_load, b_wrap, b_done;
    logic [2:0] b_lv, b_count;
    logic [1:0] b_mode;

    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;
    exp_t q[$];
    mstate_t ma = '{default: 0};
    mstate_t mb = '{default: 0};

    always #5 clk = ~clk;

    stim_counter #(.WIDTH(2), .SWEEPS(2)) dut_a (
        .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .load_val(a_lv),
        .mode(a_mode), .count(a_count), .wrap(a_wrap), .done(a_done)
    );

    stim_counter #(.WIDTH(3), .SWEEPS(1)) dut_b (
        .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .load_val(b_lv),
        .mode(b_mode), .count(b_count), .wrap(b_wrap), .done(b_done)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cycle, act, exp);
        end
    endtask

    // Reference model: the counter position lives in the integer range
    // [0, 2^width) and moves by +/-1 modulo the range size. A sweep completes
    // when the position leaves its last point in the current direction.
    function automatic int gray(int v);
        return v ^ (v >> 1);
    endfunction

    function automatic mstate_t model_next(mstate_t s, int width, int sweeps, in_t x);
        int      size;
        mstate_t n;
        size = 1 << width;
        n    = s;
        if (x.rst) begin
            n = '{default: 0};
        end else if (x.load) begin
            n.bin    = x.lv % size;
            n.sweeps = 0;
            n.done   = 0;
            n.wrap   = 0;
            n.cnt    = (x.mode == 2) ? gray(n.bin) : n.bin;
        end else if (s.done) begin
            n.wrap = 0;
        end else begin
            n.wrap = 0;
            if (x.en && x.mode != 3) begin
                if (x.mode == 1) begin
                    n.wrap = (s.bin == 0);
                    n.bin  = (s.bin + size - 1) % size;
                end else begin
                    n.wrap = (s.bin == size - 1);
                    n.bin  = (s.bin + 1) % size;
                end
                if (n.wrap) begin
                    n.sweeps = s.sweeps + 1;
                    if (n.sweeps == sweeps) n.done = 1;
                end
            end
            n.cnt = (x.mode == 2) ? gray(n.bin) : n.bin;
        end
        return n;
    endfunction

    function automatic in_t mk(bit rst, bit load, int lv, int mode, bit en);
        in_t x;
        x.rst  = rst;
        x.load = load;
        x.lv   = lv;
        x.mode = mode;
        x.en   = en;
        return x;
    endfunction

    function automatic in_t rnd(int lvmax);
        in_t x;
        x.rst  = ($urandom_range(0, 49) == 0);
        x.load = ($urandom_range(0, 14) == 0);
        x.lv   = int'($urandom_range(0, lvmax));
        x.mode = int'($urandom_range(0, 3));
        x.en   = ($urandom_range(0, 4) != 0);
        return x;
    endfunction

    // Drive one cycle of stimulus into both instances and record the
    // predicted outputs once the edge has occurred.
    task automatic step(input in_t ia, input in_t ib);
        exp_t e;
        a_rst  = ia.rst;
        a_load = ia.load;
        a_lv   = 2'(ia.lv);
        a_mode = 2'(ia.mode);
        a_en   = ia.en;
        b_rst  = ib.rst;
        b_load = ib.load;
        b_lv   = 3'(ib.lv);
        b_mode = 2'(ib.mode);
        b_en   = ib.en;
        ma = model_next(ma, 2, 2, ia);
        mb = model_next(mb, 3, 1, ib);
        e.ca = ma.cnt;
        e.wa = ma.wrap;
        e.da = ma.done;
        e.cb = mb.cnt;
        e.wb = mb.wrap;
        e.db = mb.done;
        @(posedge clk);
        q.push_back(e);
        #1;
    endtask

    // Monitor: outputs are registered and change every cycle, so one
    // expectation is consumed per clock, sampled away from the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            cycle++;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("a_count", 32'(a_count), 32'(e.ca));
                check("a_wrap",  32'(a_wrap),  32'(e.wa));
                check("a_done",  32'(a_done),  32'(e.da));
                check("b_count", 32'(b_count), 32'(e.cb));
                check("b_wrap",  32'(b_wrap),  32'(e.wb));
                check("b_done",  32'(b_done),  32'(e.db));
            end
        end
    end

    initial begin
        // Reset both instances.
        step(mk(1, 0, 0, 0, 0), mk(1, 0, 0, 0, 0));

        // Binary up on A: 1,2,3,0,1,2,3,0, with done on the 8th value,
        // followed by a 3-cycle hold. B sees random traffic.
        for (int i = 0; i < 11; i++) step(mk(0, 0, 0, 0, 1), rnd(7));

        // Gray up on A from reset: 01,11,10,00.
        step(mk(1, 0, 0, 2, 0), rnd(7));
        for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 2, 1), rnd(7));

        // Down on B: load 2, then 1,0,7 with wrap and done at 7, then hold.
        step(rnd(3), mk(0, 1, 2, 1, 0));
        for (int i = 0; i < 5; i++) step(rnd(3), mk(0, 0, 0, 1, 1));

        // Load beats enable while B is done; the next enabled edge gives 6.
        step(rnd(3), mk(0, 1, 5, 0, 1));
        step(rnd(3), mk(0, 0, 0, 0, 1));

        // Reset A mid-sweep at count 3 with en high, then hold mode.
        step(mk(1, 0, 0, 0, 0), rnd(7));
        for (int i = 0; i < 3; i++) step(mk(0, 0, 0, 0, 1), rnd(7));
        step(mk(1, 0, 0, 0, 1), rnd(7));
        for (int i = 0; i < 4; i++) step(mk(0, 0, 0, 3, 1), rnd(7));

        // Random traffic on both instances.
        for (int i = 0; i < 500; i++) step(rnd(3), rnd(7));

        // Let the monitor consume the last expectation.
        repeat (3) @(posedge clk);
        #4;
        check("queue_drained", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stim_counter.md
# stim_counter

Parametrised stimulus counter that sweeps a WIDTH-bit input space for exhaustive checking of combinational DUTs in unit benches. It supports binary-up, binary-down and Gray-code sequences, a synchronous load, a per-wrap pulse, and a sticky done flag after a programmable number of full sweeps. It sits between the bench clock generator and the DUT input pins, with the DUT inputs taken as slices of `count`.

## Interface
- `WIDTH`, default 2: counter and output width, 1..16.
- `SWEEPS`, default 1: number of full sweeps (wraps) before `done` asserts, 1..255.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: advance enable.
- `load`  in  1: synchronous load strobe.
- `load_val`  in  WIDTH: value loaded into the internal binary state.
- `mode`  in  2: sequence select.
  - 00 is binary up.
  - 01 is binary down.
  - 10 is Gray up.
  - 11 holds (no advance, no wrap).
- `count`  out  WIDTH: registered stimulus value.
- `wrap`  out  1: one-cycle pulse marking a sweep boundary.
- `done`  out  1: sticky flag, set when SWEEPS wraps have completed.

## Operation
- Internal state:
  - `bin`, a WIDTH-bit binary register.
  - `nsweep`, a sweep counter of width clog2(SWEEPS+1).
- `count` is registered:
  - In modes 00, 01 and 11 it equals `bin`.
  - In mode 10 it equals `bin ^ (bin >> 1)`, the Gray code of `bin`.
  - `count` always reflects the `bin` value and mode latched at the same edge.
- Priority per edge: `rst` > `load` > (`en` and not `done`) > hold.
- `rst`: clears `bin`, `count`, `wrap`, `done` and `nsweep` to 0.
- `load`:
  - Sets `bin` to `load_val`.
  - Clears `nsweep`, `done` and `wrap`.
  - `count` shows the loaded value encoded per the current mode.
- Advance, when `en` is 1, `done` is 0 and `mode` is not 11:
  - Modes 00 and 10: `bin` becomes `bin + 1`, modulo 2^WIDTH.
  - Mode 01: `bin` becomes `bin - 1`, modulo 2^WIDTH.
- Wrap event, on an advancing edge:
  - Modes 00 and 10: wrap occurs when `bin` is all-ones before the edge.
  - Mode 01: wrap occurs when `bin` is 0 before the edge.
  - On a wrap edge, `wrap` is 1 for the following cycle; on every other edge `wrap` is 0.
  - On a wrap edge, `nsweep` increments.
  - If `nsweep + 1` equals SWEEPS, `done` sets on that same edge.
- While `done` is 1:
  - `bin`, `count` and `nsweep` hold regardless of `en`.
  - `wrap` returns to 0.
  - Only `rst` or `load` restarts the counter.
- Mode change mid-sweep:
  - `bin` is preserved.
  - The new direction and encoding apply from the next edge.
  - `nsweep` is not cleared.
- Mode 11 with `en` high: `count` is re-encoded as `bin` and holds; no wrap occurs.
- `load` and `en` together: the load wins and there is no advance on that edge.

## Timing
- Latency is one cycle from `en` sampled high to the new `count`.
- `wrap` and `done` are registered and change on the same edge that moves `count` to the wrapped value.
  - Up mode: `wrap` is high exactly while `count` shows 0 after the wrap.
  - Down mode: `wrap` is high exactly while `count` shows all-ones after the wrap.
- Reset values: `count` = 0, `wrap` = 0, `done` = 0.
- `rst` asserted mid-sweep returns everything to the reset values on that edge; `en` is ignored on that edge.
- Full-sweep length is 2^WIDTH enabled edges per wrap.
- With `en` held high from reset, `done` sets after SWEEPS × 2^WIDTH enabled edges.
- Outputs are glitch-free: no combinational path from any input to any output.

## Test plan
- Binary up:
  - Setup: WIDTH=2, SWEEPS=2, mode=00, `rst` for 1 cycle, then `en`=1.
  - `count` must run 1,2,3,0,1,2,3,0.
  - `wrap` must be high in the cycles showing the 4th and 8th values.
  - `done` must set with the 8th value; `count` must then hold 0 for 3 further cycles.
- Gray:
  - Setup: WIDTH=2, mode=10, `en`=1 from reset.
  - `count` must run 01,11,10,00.
  - `wrap` must be high with 00; consecutive values must differ in exactly one bit.
- Down:
  - Setup: WIDTH=3, mode=01, `load_val`=2, `load` pulse, then `en`=1.
  - `count` must run 2,1,0,7.
  - `wrap` must be high with 7.
  - With SWEEPS=1, `done` must be 1 from the 7 onward.
- Load vs enable:
  - Stimulus: `load`=1 with `en`=1 and `load_val`=5 (WIDTH=3, mode=00) while `done`=1.
  - Required: `count`=5, `done`=0, `wrap`=0; the next enabled edge gives `count`=6.
- Reset mid-operation and hold:
  - Stimulus: assert `rst` while `count`=3 with `en` high.
  - Required: next cycle `count`=0, `wrap`=0, `done`=0.
  - Stimulus: mode=11 with `en`=1 for 4 cycles.
  - Required: `count` stays 0 and `wrap` stays 0.
